// File: rtl/frame_power_pkg.sv
// Shared defaults and width helpers for the frame energy accumulator.
package frame_power_pkg;

    localparam int W_DEF         = 8;
    localparam int FRAME_LEN_DEF = 256;

    // Ceiling log2, returns 0 for v <= 1.
    function automatic int clog2_int(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int mag_width(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int acc_width(input int w, input int frame_len);
        return mag_width(w) + clog2_int(frame_len);
    endfunction

endpackage

// File: rtl/cmag_sq.sv
// Two-stage magnitude-squared pipeline: P1 registers re^2 and im^2, P2 registers their sum.
module cmag_sq
    import frame_power_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int MAG_W = mag_width(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [W-1:0]     in_real,
    input  logic [W-1:0]     in_imag,
    output logic             mag_valid,
    output logic [MAG_W-1:0] mag
);

    logic [2*W-1:0]   re_ext;
    logic [2*W-1:0]   im_ext;
    logic [2*W-1:0]   re2_reg;
    logic [2*W-1:0]   im2_reg;
    logic             p1_valid_reg;
    logic [MAG_W-1:0] mag_reg;
    logic             p2_valid_reg;

    assign re_ext = {{W{1'b0}}, in_real};
    assign im_ext = {{W{1'b0}}, in_imag};

    always_ff @(posedge clk) begin
        if (rst) begin
            re2_reg      <= '0;
            im2_reg      <= '0;
            p1_valid_reg <= 1'b0;
            mag_reg      <= '0;
            p2_valid_reg <= 1'b0;
        end else if (clr) begin
            // Flush in-flight samples; data registers are don't-care once invalid.
            p1_valid_reg <= 1'b0;
            p2_valid_reg <= 1'b0;
        end else begin
            p1_valid_reg <= in_valid;
            p2_valid_reg <= p1_valid_reg;
            if (in_valid) begin
                re2_reg <= re_ext * re_ext;
                im2_reg <= im_ext * im_ext;
            end
            if (p1_valid_reg) begin
                mag_reg <= MAG_W'(re2_reg) + MAG_W'(im2_reg);
            end
        end
    end

    assign mag_valid = p2_valid_reg;
    assign mag       = mag_reg;

endmodule

// File: rtl/frame_power_acc.sv
// Frame energy accumulator with a double-buffered ready/valid result.
// Optional peak-magnitude output enabled by defining FRAME_POWER_PEAK_EN.
module frame_power_acc
    import frame_power_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int MAG_W     = mag_width(W),
    parameter int ACC_W     = acc_width(W, FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_real,
    input  logic [W-1:0]     in_imag,
    input  logic             clr,
    input  logic             frame_end,
    output logic [ACC_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overrun,
    output logic             sync_err
`ifdef FRAME_POWER_PEAK_EN
    ,
    output logic [MAG_W-1:0] res_peak
`endif
);

    localparam int CNT_W = clog2_int(FRAME_LEN);

    logic             accept;
    logic             is_last;
    logic             mag_valid;
    logic [MAG_W-1:0] mag;
    logic             close;
    logic             load;
    logic [ACC_W-1:0] sum;

    logic [CNT_W-1:0] cnt_reg;
    logic             last_p1_reg;
    logic             last_p2_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] res_data_reg;
    logic             res_valid_reg;
    logic             overrun_reg;
    logic             sync_err_reg;

    assign accept  = in_valid & ~clr;
    assign is_last = (cnt_reg == CNT_W'(FRAME_LEN - 1));

    cmag_sq #(
        .W     (W),
        .MAG_W (MAG_W)
    ) u_cmag_sq (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (accept),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .mag_valid (mag_valid),
        .mag       (mag)
    );

    // A close on a clr edge belongs to a discarded sample, so it is suppressed.
    assign close = mag_valid & last_p2_reg & ~clr;
    assign load  = close & (~res_valid_reg | res_ready);
    assign sum   = acc_reg + ACC_W'(mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            last_p1_reg <= 1'b0;
            last_p2_reg <= 1'b0;
            acc_reg     <= '0;
        end else if (clr) begin
            cnt_reg     <= '0;
            last_p1_reg <= 1'b0;
            last_p2_reg <= 1'b0;
            acc_reg     <= '0;
        end else begin
            last_p1_reg <= accept & is_last;
            last_p2_reg <= last_p1_reg;
            if (accept) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (close) begin
                acc_reg <= '0;
            end else if (mag_valid) begin
                acc_reg <= sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_reg  <= '0;
            res_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            sync_err_reg  <= 1'b0;
        end else begin
            if (load) begin
                res_data_reg  <= sum;
                res_valid_reg <= 1'b1;
            end else if (close) begin
                overrun_reg <= 1'b1;
            end else if (res_valid_reg && res_ready) begin
                res_valid_reg <= 1'b0;
            end
            if (accept && frame_end && !is_last) begin
                sync_err_reg <= 1'b1;
            end
        end
    end

`ifdef FRAME_POWER_PEAK_EN
    logic [MAG_W-1:0] peak_reg;
    logic [MAG_W-1:0] peak_next;
    logic [MAG_W-1:0] res_peak_reg;

    assign peak_next = (mag > peak_reg) ? mag : peak_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_reg     <= '0;
            res_peak_reg <= '0;
        end else begin
            if (clr || close) begin
                peak_reg <= '0;
            end else if (mag_valid) begin
                peak_reg <= peak_next;
            end
            if (load) begin
                res_peak_reg <= peak_next;
            end
        end
    end

    assign res_peak = res_peak_reg;
`endif

    assign res_data  = res_data_reg;
    assign res_valid = res_valid_reg;
    assign overrun   = overrun_reg;
    assign sync_err  = sync_err_reg;

endmodule

// File: tb/tb_frame_power_acc.sv
// Directed testbench for frame_power_acc; peak checks compile in when FRAME_POWER_PEAK_EN is defined.
module tb_frame_power_acc;

    localparam int W     = 8;
    localparam int MAG_W = 17;
    localparam int ACC_W = 25;

    localparam logic [63:0] RAMP_E = 64'd11119360;
    localparam logic [63:0] MAX_E  = 64'd33292800;
    localparam logic [63:0] ONES_E = 64'd512;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_real = '0;
    logic [W-1:0]     in_imag = '0;
    logic             clr = 1'b0;
    logic             frame_end = 1'b0;
    logic [ACC_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             overrun;
    logic             sync_err;
`ifdef FRAME_POWER_PEAK_EN
    logic [MAG_W-1:0] res_peak;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    logic [ACC_W-1:0] xfer_data = '0;
    int x0;

    frame_power_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .clr       (clr),
        .frame_end (frame_end),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .overrun   (overrun),
        .sync_err  (sync_err)
`ifdef FRAME_POWER_PEAK_EN
        ,
        .res_peak  (res_peak)
`endif
    );

    always #5 clk = ~clk;

    // Record every completed handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            xfer_cnt  = xfer_cnt + 1;
            xfer_data = res_data;
            $display("xfer %0d: res_data=%0d at %0t", xfer_cnt, res_data, $time);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // n samples, one every gap cycles; val < 0 gives re=im=k, else re=im=val.
    task automatic frame(input int n, input int gap, input int fe_at, input int val);
        for (int k = 0; k < n; k++) begin
            in_valid  = 1'b1;
            in_real   = (val < 0) ? W'(k) : W'(val);
            in_imag   = in_real;
            frame_end = (k == fe_at);
            tick(1);
            in_valid  = 1'b0;
            frame_end = 1'b0;
            tick(gap - 1);
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_sync_err", 64'(sync_err), 64'd0);
`ifdef FRAME_POWER_PEAK_EN
        chk("rst_res_peak", 64'(res_peak), 64'd0);
`endif
        rst = 1'b0;
        tick(1);

        // Spaced ramp with aligned frame_end
        res_ready = 1'b1;
        x0 = xfer_cnt;
        frame(256, 4, 255, -1);
        tick(2);
        chk("ramp_xfers", 64'(xfer_cnt - x0), 64'd1);
        chk("ramp_data", 64'(xfer_data), RAMP_E);
        chk("ramp_sync_err", 64'(sync_err), 64'd0);
        chk("ramp_valid_low", 64'(res_valid), 64'd0);

        // Max input, back-to-back, latency check
        frame(256, 1, 255, 255);
        chk("max_lat_p1", 64'(res_valid), 64'd0);
        tick(1);
        chk("max_lat_p2", 64'(res_valid), 64'd0);
        tick(1);
        chk("max_valid", 64'(res_valid), 64'd1);
        chk("max_data", 64'(res_data), MAX_E);
`ifdef FRAME_POWER_PEAK_EN
        chk("max_peak", 64'(res_peak), 64'd130050);
`endif
        tick(1);
        chk("max_valid_drop", 64'(res_valid), 64'd0);
        chk("max_sync_err", 64'(sync_err), 64'd0);

        // Backpressure: first result held, second dropped
        res_ready = 1'b0;
        frame(256, 1, -1, -1);
        tick(2);
        chk("bp_valid1", 64'(res_valid), 64'd1);
        chk("bp_data1", 64'(res_data), RAMP_E);
        chk("bp_overrun0", 64'(overrun), 64'd0);
        frame(256, 1, -1, 1);
        tick(2);
        chk("bp_held_valid", 64'(res_valid), 64'd1);
        chk("bp_held_data", 64'(res_data), RAMP_E);
        chk("bp_overrun1", 64'(overrun), 64'd1);
        x0 = xfer_cnt;
        res_ready = 1'b1;
        tick(1);
        chk("bp_xfers", 64'(xfer_cnt - x0), 64'd1);
        chk("bp_xfer_data", 64'(xfer_data), RAMP_E);
        chk("bp_valid_after", 64'(res_valid), 64'd0);

        // clr mid-frame
        do_reset();
        chk("clr_pre_overrun", 64'(overrun), 64'd0);
        x0 = xfer_cnt;
        frame(100, 1, -1, -1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        frame(256, 1, -1, -1);
        tick(3);
        chk("clr_xfers", 64'(xfer_cnt - x0), 64'd1);
        chk("clr_data", 64'(xfer_data), RAMP_E);
        chk("clr_overrun", 64'(overrun), 64'd0);

        // frame_end misaligned at cnt=10
        x0 = xfer_cnt;
        frame(256, 1, 10, -1);
        tick(3);
        chk("mis_sync_err", 64'(sync_err), 64'd1);
        chk("mis_xfers", 64'(xfer_cnt - x0), 64'd1);
        chk("mis_data", 64'(xfer_data), RAMP_E);

        // Reset while holding a result with overrun set
        res_ready = 1'b0;
        frame(256, 1, -1, -1);
        tick(2);
        chk("hold_valid", 64'(res_valid), 64'd1);
        frame(256, 1, -1, 1);
        tick(2);
        chk("hold_overrun", 64'(overrun), 64'd1);
        do_reset();
        chk("rh_valid", 64'(res_valid), 64'd0);
        chk("rh_data", 64'(res_data), 64'd0);
        chk("rh_overrun", 64'(overrun), 64'd0);
        chk("rh_sync_err", 64'(sync_err), 64'd0);
        res_ready = 1'b1;
        frame(256, 1, -1, 1);
        tick(2);
        chk("rh_next_valid", 64'(res_valid), 64'd1);
        chk("rh_next_data", 64'(res_data), ONES_E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
